// File: rtl/uart_pkg.sv
// Shared UART definitions: TX/RX state encoding and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_LINE = 1'b1;
    localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/axis_uart_tx_if.sv
// AXI4-Stream byte channel feeding the UART transmitter.
interface axis_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_uart_tx_fifo.sv
// Small synchronous FIFO with registered first-word-fall-through read and registered full flag.
module axis_uart_tx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      wr_ptr_next, rd_ptr_next;
    logic [WIDTH-1:0] rd_data_reg;
    logic             full_reg;

    assign wr_ptr_next = wr_ptr_reg + (AW+1)'(push);
    assign rd_ptr_next = rd_ptr_reg + (AW+1)'(pop);

    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = full_reg;
    assign rd_data = rd_data_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    // Output register pre-fetches the next head; bypass when that slot is written this cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            full_reg    <= 1'b1;
            rd_data_reg <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            full_reg    <= ((wr_ptr_next - rd_ptr_next) == (AW+1)'(DEPTH));
            rd_data_reg <= (push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]))
                           ? wr_data : mem[rd_ptr_next[AW-1:0]];
        end
    end
endmodule

// File: rtl/axis_uart_tx.sv
// AXIS-to-UART transmitter: FIFO-buffered bytes serialized LSB first with frame/packet end pulses.
// Define AXIS_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module axis_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int BAUD_RATE_BUS = 15,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     pi_clk,
    input  logic                     pi_rst,
    input  logic [BAUD_RATE_BUS-1:0] pi_baud_rate,
    input  logic                     pi_stop_bits,
    axis_uart_tx_if.slave            s_axis,
    output logic                     po_ut_data,
    output logic                     po_busy,
    output logic                     po_tran_over,
    output logic                     po_tlast_over
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t                state_reg;
    logic [BAUD_RATE_BUS-1:0] presc_reg;
    logic [BAUD_RATE_BUS-1:0] baud_reg;
    logic [DATA_WIDTH-1:0]    shift_reg;
    logic [BW-1:0]            bit_cnt_reg;
    logic                     stop_cnt_reg;
    logic                     stop_bits_reg;
    logic                     tlast_reg;
    logic                     line_reg;
`ifdef AXIS_UART_TX_PARITY_EN
    logic                     parity_reg;
`endif

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH:0]   fifo_rd_data;
    logic [CW-1:0]         fifo_count;
    logic                  bit_strobe;
    logic                  stop_done;

    assign s_axis.tready = !fifo_full;
    assign fifo_push     = s_axis.tvalid && !fifo_full;
    assign fifo_pop      = (state_reg == IDLE) && !fifo_empty;
    assign bit_strobe    = (presc_reg == baud_reg);
    assign stop_done     = (state_reg == STOP) && bit_strobe && (stop_cnt_reg == stop_bits_reg);

    axis_uart_tx_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (pi_clk),
        .srst    (pi_rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({s_axis.tlast, s_axis.tdata}),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Line level is registered: each state writes the level for the following cycle.
    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            state_reg     <= IDLE;
            presc_reg     <= '0;
            baud_reg      <= '0;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            stop_cnt_reg  <= 1'b0;
            stop_bits_reg <= 1'b0;
            tlast_reg     <= 1'b0;
            line_reg      <= IDLE_LINE;
`ifdef AXIS_UART_TX_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            presc_reg <= (state_reg == IDLE || bit_strobe) ? '0 : presc_reg + 1'b1;
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift_reg     <= fifo_rd_data[DATA_WIDTH-1:0];
                        tlast_reg     <= fifo_rd_data[DATA_WIDTH];
                        baud_reg      <= pi_baud_rate;
                        stop_bits_reg <= pi_stop_bits;
                        bit_cnt_reg   <= '0;
                        stop_cnt_reg  <= 1'b0;
                        line_reg      <= START_LVL;
                        state_reg     <= START;
`ifdef AXIS_UART_TX_PARITY_EN
                        parity_reg    <= ^fifo_rd_data[DATA_WIDTH-1:0];
`endif
                    end
                end
                START: begin
                    if (bit_strobe) begin
                        line_reg  <= shift_reg[0];
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (bit_strobe) begin
                        if (bit_cnt_reg == BW'(DATA_WIDTH - 1)) begin
`ifdef AXIS_UART_TX_PARITY_EN
                            line_reg  <= parity_reg;
                            state_reg <= PARITY;
`else
                            line_reg  <= IDLE_LINE;
                            state_reg <= STOP;
`endif
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            shift_reg   <= shift_reg >> 1;
                            line_reg    <= shift_reg[1];
                        end
                    end
                end
`ifdef AXIS_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_strobe) begin
                        line_reg  <= IDLE_LINE;
                        state_reg <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_strobe) begin
                        if (stop_cnt_reg == stop_bits_reg) begin
                            state_reg <= IDLE;
                        end else begin
                            stop_cnt_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    line_reg  <= IDLE_LINE;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign po_ut_data    = line_reg;
    assign po_busy       = (state_reg != IDLE) || (fifo_count != '0);
    assign po_tran_over  = stop_done;
    assign po_tlast_over = stop_done && tlast_reg;
endmodule

// File: tb/tb_axis_uart_tx.sv
// Bench for axis_uart_tx: waveform-level model compared every cycle plus hand-computed frame patterns.
module tb_axis_uart_tx;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [14:0] baud;
    logic        stop2;
    logic        ut_data, busy, tran_over, tlast_over;

    axis_uart_tx_if #(.DATA_WIDTH(8)) s_axis_if ();

    axis_uart_tx #(
        .DATA_WIDTH    (8),
        .BAUD_RATE_BUS (15),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .pi_clk        (clk),
        .pi_rst        (rst),
        .pi_baud_rate  (baud),
        .pi_stop_bits  (stop2),
        .s_axis        (s_axis_if),
        .po_ut_data    (ut_data),
        .po_busy       (busy),
        .po_tran_over  (tran_over),
        .po_tlast_over (tlast_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame as a sequence of line levels: start, data LSB first, optional parity, stops.
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef AXIS_UART_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    function automatic int frame_len(input logic two);
`ifdef AXIS_UART_TX_PARITY_EN
        return two ? 12 : 11;
`else
        return two ? 11 : 10;
`endif
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         k;
    } ent_t;

    ent_t       q[$];
    ent_t       e;
    int         cyc = 0;
    int         hs_cnt = 0;
    int         cur_s = 0, cur_f = -10, cur_bp = 1;
    logic [7:0] cur_d = '0;
    logic       cur_last = 1'b0;
    bit         exp_rst = 1'b0;
    bit         started = 1'b0;

    // Scheduling model: a frame starts at the edge after its handshake, but no earlier than
    // two cycles after the previous frame's final stop cycle.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                cur_s   = 0;
                cur_f   = -10;
                exp_rst = 1'b1;
                started = 1'b1;
            end else begin
                exp_rst = 1'b0;
                if (s_axis_if.tvalid && s_axis_if.tready) begin
                    q.push_back('{d: s_axis_if.tdata, l: s_axis_if.tlast, k: cyc});
                    hs_cnt++;
                end
                if (cyc >= cur_f + 2 && q.size() > 0 && q[0].k < cyc) begin
                    e        = q.pop_front();
                    cur_s    = cyc;
                    cur_bp   = int'(baud) + 1;
                    cur_d    = e.d;
                    cur_last = e.l;
                    cur_f    = cyc + frame_len(stop2) * cur_bp - 1;
                    $display("tx frame data=%02h tlast=%0b bit_clks=%0d stop_bits=%0d start_cycle=%0d",
                             e.d, e.l, cur_bp, stop2 ? 2 : 1, cyc);
                end
            end
        end
    end

    initial begin
        logic in_fr, exp_line, exp_to;
        forever begin
            @(negedge clk);
            if (started) begin
                in_fr    = (cyc >= cur_s) && (cyc <= cur_f);
                exp_line = in_fr ? frame_bit(cur_d, (cyc - cur_s) / cur_bp) : 1'b1;
                exp_to   = in_fr && (cyc == cur_f);
                chk("line", 32'(ut_data), 32'(exp_line));
                chk("tran_over", 32'(tran_over), 32'(exp_to));
                chk("tlast_over", 32'(tlast_over), 32'(exp_to && cur_last));
                chk("tready", 32'(s_axis_if.tready), 32'(!exp_rst && q.size() != DEPTH));
                chk("busy", 32'(busy), 32'(in_fr || q.size() > 0));
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int t = 0;
        s_axis_if.tdata  = d;
        s_axis_if.tlast  = l;
        s_axis_if.tvalid = 1'b1;
        while (s_axis_if.tready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("send_timeout", 32'(s_axis_if.tready), 32'd1);
        @(negedge clk);
    endtask

    // Waits for a start bit, then checks every cycle of the frame against a literal pattern.
    task automatic check_frame(input string name, input logic [15:0] pat, input int nbits,
                               input int bp, input logic exp_tl);
        int t = 0;
        while (ut_data !== 1'b0 && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (t >= 600) begin
            chk({name, "_start_timeout"}, 32'(ut_data), 32'd0);
            return;
        end
        for (int i = 0; i < nbits * bp; i++) begin
            chk({name, "_bit"}, 32'(ut_data), 32'(pat[i / bp]));
            if (i == nbits * bp - 1) begin
                chk({name, "_tran_over"}, 32'(tran_over), 32'd1);
                chk({name, "_tlast_over"}, 32'(tlast_over), 32'(exp_tl));
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) chk("idle_timeout", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

`ifdef AXIS_UART_TX_PARITY_EN
    localparam logic [15:0] PAT_55 = 16'h04AA;
    localparam int          LEN_55 = 11;
    localparam logic [15:0] PAT_A3 = 16'h0D46;
    localparam int          LEN_A3 = 12;
    localparam logic [15:0] PAT_0F = 16'h041E;
    localparam int          LEN_0F = 11;
`else
    localparam logic [15:0] PAT_55 = 16'h02AA;
    localparam int          LEN_55 = 10;
    localparam logic [15:0] PAT_A3 = 16'h0746;
    localparam int          LEN_A3 = 11;
    localparam logic [15:0] PAT_0F = 16'h021E;
    localparam int          LEN_0F = 10;
`endif

    initial begin
        rst              = 1'b1;
        baud             = 15'd3;
        stop2            = 1'b0;
        s_axis_if.tdata  = '0;
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_line", 32'(ut_data), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_tready", 32'(s_axis_if.tready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("tready_after_reset", 32'(s_axis_if.tready), 32'd1);
        repeat (2) @(negedge clk);

        // 0x55, one stop bit, 4-clk bits
        send(8'h55, 1'b0);
        s_axis_if.tvalid = 1'b0;
        check_frame("f55", PAT_55, LEN_55, 4, 1'b0);
        wait_idle();

        // 0xA3 with tlast, two stop bits
        stop2 = 1'b1;
        send(8'hA3, 1'b1);
        s_axis_if.tvalid = 1'b0;
        check_frame("fA3", PAT_A3, LEN_A3, 4, 1'b1);
        wait_idle();
        stop2 = 1'b0;

        // Six bytes back-to-back: shifter plus four FIFO slots take five, sixth waits
        begin
            int hs0;
            hs0 = hs_cnt;
            for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b0);
            chk("burst_tready_low", 32'(s_axis_if.tready), 32'd0);
            chk("burst_accepted", 32'(hs_cnt - hs0), 32'd5);
            send(8'hC6, 1'b1);
            s_axis_if.tvalid = 1'b0;
        end
        wait_idle();

        // Reset in the middle of 0xFF's data bits with another byte queued
        send(8'hFF, 1'b0);
        send(8'h11, 1'b1);
        s_axis_if.tvalid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_line", 32'(ut_data), 32'd1);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_tready", 32'(s_axis_if.tready), 32'd0);
        chk("midreset_tran_over", 32'(tran_over), 32'd0);
        repeat (60) @(negedge clk);

        // Baud change mid-frame applies from the next frame only
        send(8'h55, 1'b0);
        send(8'h0F, 1'b0);
        s_axis_if.tvalid = 1'b0;
        fork
            check_frame("baud_keep", PAT_55, LEN_55, 4, 1'b0);
            begin
                repeat (10) @(negedge clk);
                baud = 15'd7;
            end
        join
        check_frame("baud_new", PAT_0F, LEN_0F, 8, 1'b0);
        wait_idle();

`ifdef AXIS_UART_TX_PARITY_EN
        // Even parity: 0x07 -> parity 1, 0x03 -> parity 0
        baud = 15'd3;
        send(8'h07, 1'b0);
        s_axis_if.tvalid = 1'b0;
        check_frame("par07", 16'h060E, 11, 4, 1'b0);
        wait_idle();
        send(8'h03, 1'b1);
        s_axis_if.tvalid = 1'b0;
        check_frame("par03", 16'h0406, 11, 4, 1'b1);
        wait_idle();
`endif

        // One-cycle bit period, two frames back-to-back
        baud = 15'd0;
        send(8'h96, 1'b0);
        send(8'h3C, 1'b1);
        s_axis_if.tvalid = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion before %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
